// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: MEM-stage FSM states, default widths and the MEM/WB bubble.
package mips_pipe_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        MS_IDLE,
        MS_WAIT
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_unit_if.sv
// Data-memory req/ack port: master is the MEM stage, slave is the memory.
interface mem_stage_unit_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_unit_mem_wb_reg.sv
// MEM/WB pipeline register; bubble clears every field, otherwise load captures the stage results.
module mem_wb_reg #(
    parameter int DATA_W     = mips_pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic                    bubble_i,
    input  mips_pipe_pkg::wb_ctrl_t ctrl_i,
    input  logic [REG_ADDR_W-1:0]   wr_reg_i,
    input  logic [DATA_W-1:0]       read_data_i,
    input  logic [DATA_W-1:0]       alu_i,
    output mips_pipe_pkg::wb_ctrl_t ctrl_o,
    output logic [REG_ADDR_W-1:0]   wr_reg_o,
    output logic [DATA_W-1:0]       read_data_o,
    output logic [DATA_W-1:0]       alu_o
);
    import mips_pipe_pkg::*;

    wb_ctrl_t              ctrl_q;
    logic [REG_ADDR_W-1:0] wr_reg_q;
    logic [DATA_W-1:0]     read_data_q;
    logic [DATA_W-1:0]     alu_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= WB_CTRL_BUBBLE;
            wr_reg_q    <= '0;
            read_data_q <= '0;
            alu_q       <= '0;
        end else if (bubble_i) begin
            ctrl_q      <= WB_CTRL_BUBBLE;
            wr_reg_q    <= '0;
            read_data_q <= '0;
            alu_q       <= '0;
        end else if (load_i) begin
            ctrl_q      <= ctrl_i;
            wr_reg_q    <= wr_reg_i;
            read_data_q <= read_data_i;
            alu_q       <= alu_i;
        end
    end

    assign ctrl_o      = ctrl_q;
    assign wr_reg_o    = wr_reg_q;
    assign read_data_o = read_data_q;
    assign alu_o       = alu_q;
endmodule

// File: rtl/mem_stage_unit.sv
// MIPS MEM stage: BEQ resolution, req/ack load/store FSM with upstream stall, MEM/WB register.
// Optional access timeout with sticky mem_error: define MEM_STAGE_TIMEOUT_EN.
module mem_stage_unit #(
    parameter int DATA_W         = mips_pipe_pkg::DATA_W,
    parameter int REG_ADDR_W     = mips_pipe_pkg::REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Ctrl_RegWrite,
    input  logic                  in_Ctrl_MemToReg,
    input  logic                  in_Ctrl_MemRead,
    input  logic                  in_Ctrl_MemWrite,
    input  logic                  in_Ctrl_Branch_Equal,
    input  logic                  in_zero,
    input  logic [REG_ADDR_W-1:0] in_Write_Register,
    input  logic [DATA_W-1:0]     in_New_PC,
    input  logic [DATA_W-1:0]     in_ALU_Result,
    input  logic [DATA_W-1:0]     in_Write_Data,
    mem_stage_unit_if.master      dmem,
    output logic                  stall,
    output logic                  pc_src,
    output logic [DATA_W-1:0]     branch_target,
    output logic                  out_Ctrl_RegWrite,
    output logic                  out_Ctrl_MemToReg,
    output logic [REG_ADDR_W-1:0] out_Write_Register,
    output logic [DATA_W-1:0]     out_Read_Data,
    output logic [DATA_W-1:0]     out_ALU_Result,
    output logic                  mem_error
);
    import mips_pipe_pkg::*;

    mem_state_t        state_q;
    logic              req_q;
    logic              mem_op;
    logic              store_wins;
    logic              is_load;
    logic              abort;
    wb_ctrl_t          wb_ctrl_d;
    wb_ctrl_t          wb_ctrl_o;
    logic [DATA_W-1:0] read_data_d;

    assign mem_op     = in_Ctrl_MemRead | in_Ctrl_MemWrite;
    assign store_wins = in_Ctrl_MemRead & in_Ctrl_MemWrite;
    assign is_load    = in_Ctrl_MemRead & ~in_Ctrl_MemWrite;

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [6:0] wait_cnt_q;
    logic       err_q;
    assign abort     = (state_q == MS_WAIT) && !dmem.dmem_ack
                       && (wait_cnt_q == 7'(TIMEOUT_CYCLES - 1));
    assign mem_error = err_q;
`else
    assign abort     = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        if (state_q == MS_IDLE) stall = mem_op;
        else                    stall = !dmem.dmem_ack && !abort;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MS_IDLE;
            req_q   <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (mem_op) begin
                        state_q <= MS_WAIT;
                        req_q   <= 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                default: begin
                    if (dmem.dmem_ack || abort) begin
                        state_q <= MS_IDLE;
                        req_q   <= 1'b0;
                    end
`ifdef MEM_STAGE_TIMEOUT_EN
                    else wait_cnt_q <= wait_cnt_q + 7'd1;
                    if (abort) err_q <= 1'b1;
`endif
                end
            endcase
        end
    end

    // Read data is only meaningful on the completing cycle of a pure load; an abort never acks.
    assign read_data_d = (state_q == MS_WAIT && dmem.dmem_ack && is_load) ? dmem.dmem_rdata : '0;
    assign wb_ctrl_d.reg_write  = in_Ctrl_RegWrite & ~store_wins & ~abort;
    assign wb_ctrl_d.mem_to_reg = in_Ctrl_MemToReg;

    mem_wb_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb (
        .clk         (clk),
        .reset       (reset),
        .load_i      (!stall),
        .bubble_i    (stall),
        .ctrl_i      (wb_ctrl_d),
        .wr_reg_i    (in_Write_Register),
        .read_data_i (read_data_d),
        .alu_i       (in_ALU_Result),
        .ctrl_o      (wb_ctrl_o),
        .wr_reg_o    (out_Write_Register),
        .read_data_o (out_Read_Data),
        .alu_o       (out_ALU_Result)
    );

    assign out_Ctrl_RegWrite = wb_ctrl_o.reg_write;
    assign out_Ctrl_MemToReg = wb_ctrl_o.mem_to_reg;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = in_Ctrl_MemWrite;
    assign dmem.dmem_addr  = in_ALU_Result;
    assign dmem.dmem_wdata = in_Write_Data;

    assign pc_src        = in_Ctrl_Branch_Equal & in_zero & ~stall;
    assign branch_target = in_New_PC;
endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a queue of expected MEM/WB results per instruction.
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rw, mtr, mr, mw, be, zero;
    logic [4:0]  wr;
    logic [31:0] new_pc, alu, wdata;
    logic        stall, pc_src, o_rw, o_mtr, mem_error;
    logic [31:0] branch_target, o_rd, o_alu;
    logic [4:0]  o_wr;

    int n_assert = 0;
    int n_fail   = 0;
    int sc;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [4:0]  wr;
        logic [31:0] rd;
        logic [31:0] alu;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_stage_unit_if #(.DATA_W(32)) dif ();

    mem_stage_unit #(
        .DATA_W         (32),
        .REG_ADDR_W     (5),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .in_Ctrl_RegWrite     (rw),
        .in_Ctrl_MemToReg     (mtr),
        .in_Ctrl_MemRead      (mr),
        .in_Ctrl_MemWrite     (mw),
        .in_Ctrl_Branch_Equal (be),
        .in_zero              (zero),
        .in_Write_Register    (wr),
        .in_New_PC            (new_pc),
        .in_ALU_Result        (alu),
        .in_Write_Data        (wdata),
        .dmem                 (dif),
        .stall                (stall),
        .pc_src               (pc_src),
        .branch_target        (branch_target),
        .out_Ctrl_RegWrite    (o_rw),
        .out_Ctrl_MemToReg    (o_mtr),
        .out_Write_Register   (o_wr),
        .out_Read_Data        (o_rd),
        .out_ALU_Result       (o_alu),
        .mem_error            (mem_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rw = 0; mtr = 0; mr = 0; mw = 0; be = 0; zero = 0;
        wr = '0; new_pc = '0; alu = '0; wdata = '0;
    endtask

    // ack_cycle: req cycle number that gets ack (0 = never ack)
    task automatic do_instr(input string tag, input logic i_rw, input logic i_mtr,
                            input logic i_mr, input logic i_mw, input logic [4:0] i_wr,
                            input logic [31:0] i_alu, input logic [31:0] i_wdata,
                            input int ack_cycle, input logic [31:0] rdata, input int exp_stall);
        exp_t e;
        exp_t got;
        int   stall_cycles = 0;
        int   req_n = 0;
        bit   done = 0;
        @(posedge clk); #1;
        rw = i_rw; mtr = i_mtr; mr = i_mr; mw = i_mw; wr = i_wr; alu = i_alu; wdata = i_wdata;
        e.rw  = i_rw & !(i_mr & i_mw) & (!(i_mr | i_mw) || ack_cycle != 0);
        e.mtr = i_mtr;
        e.wr  = i_wr;
        e.rd  = (i_mr && !i_mw && ack_cycle != 0) ? rdata : 32'h0;
        e.alu = i_alu;
        sb.push_back(e);
        for (int c = 0; c < 200 && !done; c++) begin
            dif.dmem_ack = 1'b0;
            if (dif.dmem_req) begin
                req_n++;
                if (req_n == 1) begin
                    check({tag, "_we"},    dif.dmem_we,    i_mw);
                    check({tag, "_addr"},  dif.dmem_addr,  i_alu);
                    check({tag, "_wdata"}, dif.dmem_wdata, i_wdata);
                end
                if (req_n == ack_cycle) begin
                    dif.dmem_ack   = 1'b1;
                    dif.dmem_rdata = rdata;
                end
            end
            @(negedge clk);
            if (stall) stall_cycles++;
            else       done = 1;
            @(posedge clk); #1;
        end
        dif.dmem_ack = 1'b0;
        dif.dmem_rdata = 32'hDEAD_BEEF;
        check({tag, "_completed"}, 32'(done), 32'd1);
        check({tag, "_stall_cycles"}, stall_cycles, exp_stall);
        got = sb.pop_front();
        check({tag, "_regwrite"}, o_rw,  got.rw);
        check({tag, "_memtoreg"}, o_mtr, got.mtr);
        check({tag, "_wreg"},     o_wr,  got.wr);
        check({tag, "_rdata"},    o_rd,  got.rd);
        check({tag, "_alu"},      o_alu, got.alu);
        check({tag, "_req_after"}, dif.dmem_req, 1'b0);
        idle_inputs();
        @(posedge clk); #1;
        check({tag, "_regwrite_pulse"}, o_rw, 1'b0);
        check({tag, "_req_idle"}, dif.dmem_req, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = '0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_req",   dif.dmem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_rw",    o_rw, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req",   dif.dmem_req, 1'b0);
        check("post_rst_stall", stall, 1'b0);
        check("post_rst_rw",    o_rw, 1'b0);
        check("post_rst_mtr",   o_mtr, 1'b0);
        check("post_rst_wr",    o_wr, 5'd0);
        check("post_rst_rd",    o_rd, 32'h0);
        check("post_rst_alu",   o_alu, 32'h0);
        check("post_rst_pcsrc", pc_src, 1'b0);
        check("post_rst_err",   mem_error, 1'b0);

        do_instr("rtype", 1, 0, 0, 0, 5'd5, 32'h10, 32'h0, 0, 32'h0, 0);
        do_instr("load",  1, 1, 1, 0, 5'd8, 32'h100, 32'h0, 3, 32'hCAFE_F00D, 3);
        do_instr("store", 0, 0, 0, 1, 5'd0, 32'h200, 32'h1234_5678, 1, 32'h0, 1);
        do_instr("ldst",  1, 1, 1, 1, 5'd9, 32'h300, 32'hA5A5_0001, 2, 32'h5555_AAAA, 2);
        do_instr("load_b2b", 1, 1, 1, 0, 5'd31, 32'hFFFF_FFFC, 32'h0, 1, 32'h0BAD_F00D, 1);

        // BEQ taken / not taken
        @(posedge clk); #1;
        be = 1; zero = 1; new_pc = 32'h40;
        #1;
        check("beq_pcsrc",  pc_src, 1'b1);
        check("beq_target", branch_target, 32'h40);
        zero = 0;
        #1;
        check("beq_nz_pcsrc", pc_src, 1'b0);
        idle_inputs();

        // Reset during an outstanding access, then a late ack
        @(posedge clk); #1;
        mr = 1; rw = 1; alu = 32'h400; wr = 5'd3;
        @(posedge clk); #1;
        check("midrst_req_up", dif.dmem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("midrst_req_drop", dif.dmem_req, 1'b0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        dif.dmem_ack = 1'b1;
        dif.dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        check("lateack_stall", stall, 1'b0);
        @(posedge clk); #1;
        dif.dmem_ack = 1'b0;
        check("lateack_req", dif.dmem_req, 1'b0);
        check("lateack_rw",  o_rw, 1'b0);
        check("lateack_rd",  o_rd, 32'h0);

`ifdef MEM_STAGE_TIMEOUT_EN
        do_instr("timeout", 1, 1, 1, 0, 5'd4, 32'h500, 32'h0, 0, 32'h0, 64);
        check("timeout_err", mem_error, 1'b1);
        @(posedge clk); #1;
        check("timeout_err_sticky", mem_error, 1'b1);
`else
        check("err_tied", mem_error, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
